reg_file_scoreboard: RTL and testbench

- Parametrised successor to the 8x16 register bank for the pipelined RISC core.
- Two asynchronous read ports and one synchronous write port.
- Per-register outstanding-write counters, so decode can detect RAW hazards against in-flight producers without a separate scoreboard.
- Sits between decode (reads, claims) and writeback (writes).

---
 rtl/reg_file_scoreboard.sv | 87 ++++++++
 tb/tb_reg_file_scoreboard.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: register bank with per-register outstanding-write counters.
// Ports:
//   clk, reset               - clock; synchronous active-high reset
//   readAdd1/2 -> readData1/2 - asynchronous read ports
//   readBusy1/2              - register at readAddN has an outstanding write
//   writeEnable/writeAdd/writeData - writeback port (also retires one claim)
//   claimEnable/claimAdd     - decode claims a destination register
//   flush                    - clears every outstanding count
//   pendError                - sticky counter overflow/underflow flag
// Optional: define REGFILE_BYPASS_EN for write-through read forwarding.
module reg_file_scoreboard #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int PEND_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] readAdd1,
   input  logic [ADDR_W-1:0] readAdd2,
   output logic [DATA_W-1:0] readData1,
   output logic [DATA_W-1:0] readData2,
   output logic              readBusy1,
   output logic              readBusy2,
   input  logic              writeEnable,
   input  logic [ADDR_W-1:0] writeAdd,
   input  logic [DATA_W-1:0] writeData,
   input  logic              claimEnable,
   input  logic [ADDR_W-1:0] claimAdd,
   input  logic              flush,
   output logic              pendError
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [PEND_W-1:0] MAX_CNT = '1;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [PEND_W-1:0] count [DEPTH];
   logic [PEND_W-1:0] countNext [DEPTH];
   logic [DEPTH-1:0] incHot, decHot;
   logic errNext;
   assign incHot = claimEnable ? DEPTH'(1) << claimAdd : '0;
   assign decHot = writeEnable ? DEPTH'(1) << writeAdd : '0;
   // A claim and a retiring write to the same register cancel out, so no error is possible then.
   always_comb begin
      errNext = 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
         countNext[r] = count[r];
         if (flush)
            countNext[r] = '0;
         else if (incHot[r] && !decHot[r]) begin
            if (count[r] == MAX_CNT) errNext = 1'b1;
            else countNext[r] = count[r] + 1'b1;
         end else if (decHot[r] && !incHot[r]) begin
            if (count[r] == '0) errNext = 1'b1;
            else countNext[r] = count[r] - 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i]  <= DATA_W'(i);
            count[i] <= '0;
         end
         pendError <= 1'b0;
      end else begin
         if (writeEnable) regs[writeAdd] <= writeData;
         for (int i = 0; i < DEPTH; i++) count[i] <= countNext[i];
         if (errNext) pendError <= 1'b1;
      end
   end
`ifdef REGFILE_BYPASS_EN
   logic hit1, hit2;
   assign hit1 = writeEnable && writeAdd == readAdd1;
   assign hit2 = writeEnable && writeAdd == readAdd2;
   assign readData1 = hit1 ? writeData : regs[readAdd1];
   assign readData2 = hit2 ? writeData : regs[readAdd2];
   // The write in flight retires the last producer unless a new claim lands on the same register.
   assign readBusy1 = count[readAdd1] != '0 &&
      !(hit1 && count[readAdd1] == PEND_W'(1) && !(claimEnable && claimAdd == readAdd1));
   assign readBusy2 = count[readAdd2] != '0 &&
      !(hit2 && count[readAdd2] == PEND_W'(1) && !(claimEnable && claimAdd == readAdd2));
`else
   assign readData1 = regs[readAdd1];
   assign readData2 = regs[readAdd2];
   assign readBusy1 = count[readAdd1] != '0;
   assign readBusy2 = count[readAdd2] != '0;
`endif
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb_reg_file_scoreboard: directed and random checks of reg_file_scoreboard against an event-level model.
module tb_reg_file_scoreboard;
   localparam int MAXC = 3;
   logic clk = 1'b0;
   logic reset, writeEnable, claimEnable, flush;
   logic [2:0] readAdd1, readAdd2, writeAdd, claimAdd;
   logic [15:0] writeData, readData1, readData2;
   logic readBusy1, readBusy2, pendError;
   int compared = 0;
   int mismatched = 0;
   logic [15:0] mReg [8];
   int mCnt [8];
   bit mErr;

   reg_file_scoreboard #(.DATA_W(16), .ADDR_W(3), .PEND_W(2)) dut (
      .clk(clk), .reset(reset),
      .readAdd1(readAdd1), .readAdd2(readAdd2),
      .readData1(readData1), .readData2(readData2),
      .readBusy1(readBusy1), .readBusy2(readBusy2),
      .writeEnable(writeEnable), .writeAdd(writeAdd), .writeData(writeData),
      .claimEnable(claimEnable), .claimAdd(claimAdd),
      .flush(flush), .pendError(pendError)
   );

   always #5 clk = ~clk;

   // Applies the current inputs to the model as discrete claim/write events.
   task automatic modelUpdate();
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            mReg[i] = 16'(i);
            mCnt[i] = 0;
         end
         mErr = 0;
      end else begin
         if (writeEnable) mReg[writeAdd] = writeData;
         if (flush) begin
            for (int i = 0; i < 8; i++) mCnt[i] = 0;
         end else if (!(claimEnable && writeEnable && claimAdd == writeAdd)) begin
            if (claimEnable) begin
               if (mCnt[claimAdd] == MAXC) mErr = 1;
               else mCnt[claimAdd]++;
            end
            if (writeEnable) begin
               if (mCnt[writeAdd] == 0) mErr = 1;
               else mCnt[writeAdd]--;
            end
         end
      end
   endtask

   function automatic logic [15:0] expData(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
      if (writeEnable && writeAdd == a) return writeData;
`endif
      return mReg[a];
   endfunction

   function automatic logic expBusy(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
      if (writeEnable && writeAdd == a && mCnt[a] == 1 && !(claimEnable && claimAdd == a)) return 1'b0;
`endif
      return mCnt[a] != 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag);
      #1;
      chk({tag, "_rd1"}, 32'(readData1), 32'(expData(readAdd1)));
      chk({tag, "_rd2"}, 32'(readData2), 32'(expData(readAdd2)));
      chk({tag, "_busy1"}, 32'(readBusy1), 32'(expBusy(readAdd1)));
      chk({tag, "_busy2"}, 32'(readBusy2), 32'(expBusy(readAdd2)));
      chk({tag, "_err"}, 32'(pendError), 32'(mErr));
   endtask

   task automatic tick();
      modelUpdate();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 0; writeEnable = 0; claimEnable = 0; flush = 0;
      writeAdd = 0; claimAdd = 0; writeData = 0;
   endtask

   task automatic doReset();
      idle();
      reset = 1;
      tick();
      reset = 0;
   endtask

   initial begin
      idle();
      readAdd1 = 0; readAdd2 = 0;
      doReset();
      // Reset state
      readAdd1 = 3; readAdd2 = 7;
      checkAll("reset");
      chk("reset_rd1_lit", 32'(readData1), 32'd3);
      chk("reset_rd2_lit", 32'(readData2), 32'd7);
      chk("reset_err_lit", 32'(pendError), 32'd0);
      // Write R2 and read it back
      writeEnable = 1; writeAdd = 2; writeData = 16'hBEEF; readAdd1 = 2;
      checkAll("wr_same");
`ifdef REGFILE_BYPASS_EN
      chk("wr_same_lit", 32'(readData1), 32'h0000BEEF);
`else
      chk("wr_same_lit", 32'(readData1), 32'h00000002);
`endif
      tick();
      idle();
      checkAll("wr_next");
      chk("wr_next_lit", 32'(readData1), 32'h0000BEEF);
      // Two claims then two writes to R4
      doReset();
      readAdd1 = 4;
      claimEnable = 1; claimAdd = 4;
      checkAll("c4a");
      tick();
      chk("c4a_busy_lit", 32'(readBusy1), 32'd1);
      checkAll("c4b");
      tick();
      idle(); writeEnable = 1; writeAdd = 4; writeData = 16'h0444;
      checkAll("w4a");
      tick();
      chk("w4a_busy_lit", 32'(readBusy1), 32'd1);
      checkAll("w4b");
      tick();
      idle();
      checkAll("w4_done");
      chk("w4_busy_lit", 32'(readBusy1), 32'd0);
      chk("w4_err_lit", 32'(pendError), 32'd0);
      // Saturating claims to R1
      doReset();
      readAdd1 = 1;
      for (int k = 0; k < 4; k++) begin
         claimEnable = 1; claimAdd = 1;
         checkAll("c1");
         tick();
      end
      idle();
      checkAll("c1_sat");
      chk("c1_err_lit", 32'(pendError), 32'd1);
      for (int k = 0; k < 3; k++) begin
         writeEnable = 1; writeAdd = 1; writeData = 16'(k);
         checkAll("w1");
         tick();
      end
      idle();
      checkAll("w1_done");
      chk("w1_busy_lit", 32'(readBusy1), 32'd0);
      chk("w1_err_lit", 32'(pendError), 32'd1);
      // Simultaneous claim and write at zero count, then an underflow
      doReset();
      readAdd1 = 6; readAdd2 = 5;
      claimEnable = 1; claimAdd = 6; writeEnable = 1; writeAdd = 6; writeData = 16'h0666;
      checkAll("cw6");
      tick();
      idle();
      checkAll("cw6_after");
      chk("cw6_busy_lit", 32'(readBusy1), 32'd0);
      chk("cw6_err_lit", 32'(pendError), 32'd0);
      writeEnable = 1; writeAdd = 5; writeData = 16'h5555;
      tick();
      idle();
      checkAll("uf5");
      chk("uf5_rd_lit", 32'(readData2), 32'h00005555);
      chk("uf5_err_lit", 32'(pendError), 32'd1);
      // Flush with a concurrent write, then reset
      doReset();
      readAdd1 = 3; readAdd2 = 4;
      claimEnable = 1; claimAdd = 3;
      tick();
      claimAdd = 4;
      tick();
      idle();
      checkAll("pre_flush");
      flush = 1; writeEnable = 1; writeAdd = 3; writeData = 16'h1234;
      tick();
      idle();
      checkAll("flush");
      chk("flush_busy1_lit", 32'(readBusy1), 32'd0);
      chk("flush_busy2_lit", 32'(readBusy2), 32'd0);
      chk("flush_rd_lit", 32'(readData1), 32'h00001234);
      chk("flush_err_lit", 32'(pendError), 32'd0);
      doReset();
      checkAll("post_reset");
      chk("post_reset_rd_lit", 32'(readData1), 32'd3);
      // Random traffic
      for (int n = 0; n < 600; n++) begin
         reset = $urandom_range(0, 59) == 0;
         flush = $urandom_range(0, 24) == 0;
         claimEnable = $urandom_range(0, 1) == 1;
         writeEnable = $urandom_range(0, 1) == 1;
         claimAdd = 3'($urandom_range(0, 7));
         writeAdd = $urandom_range(0, 3) == 0 ? claimAdd : 3'($urandom_range(0, 7));
         writeData = 16'($urandom);
         readAdd1 = $urandom_range(0, 2) == 0 ? writeAdd : 3'($urandom_range(0, 7));
         readAdd2 = $urandom_range(0, 2) == 0 ? claimAdd : 3'($urandom_range(0, 7));
         checkAll("rand");
         tick();
      end
      idle();
      checkAll("final");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
